// File: rtl/conv_fft_scheduler_pkg.sv
// Shared types and constants for the FFT convolution front-end scheduler.
package conv_fft_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Cycles from fft4_2d next to valid output.
    localparam int unsigned FFT4_2D_LATENCY = 6;
    // Tile entries per image memory block.
    localparam int unsigned IMAGE_MEM_DEPTH = 256;

endpackage

// File: rtl/conv_fft_scheduler_if.sv
// Host/engine/memory-side handshake bundle of the FFT convolution scheduler.
interface conv_fft_scheduler_if #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [CNT_W-1:0]  num_lines;
    logic              cl_valid;
    logic              cl_ready;
    logic              fft_next;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              busy;
    logic              done;

    modport master (
        output start, num_lines, cl_valid,
        input  cl_ready, fft_next, mem_we, mem_addr, busy, done
    );

    modport slave (
        input  start, num_lines, cl_valid,
        output cl_ready, fft_next, mem_we, mem_addr, busy, done
    );
endinterface

// File: rtl/conv_fft_scheduler_fixed_delay_line.sv
// Fixed-length 1-bit delay line with asynchronous active-low clear.
module fixed_delay_line #(
    parameter int unsigned LEN = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic [LEN-1:0] taps;

    generate
        if (LEN == 1) begin : g_single
            // Single-stage delay.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) taps <= '0;
                else        taps <= din;
            end
        end else begin : g_chain
            // Shift din in at the bottom; the top bit is din delayed LEN cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) taps <= '0;
                else        taps <= {taps[LEN-2:0], din};
            end
        end
    endgenerate

    assign dout = taps[LEN-1];
endmodule

// File: rtl/conv_fft_scheduler.sv
// Sequencing controller: feeds cachelines into the fft4_2d engines and
// writes their results into the image memory blocks after the fixed latency.
module conv_fft_scheduler
    import conv_fft_scheduler_pkg::*;
#(
    parameter int unsigned FFT_LAT = FFT4_2D_LATENCY,
    parameter int unsigned DEPTH   = IMAGE_MEM_DEPTH,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic clk,
    input  logic reset,
    conv_fft_scheduler_if.slave bus
);
    localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    sched_state_t      state;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  written;
    logic [CNT_W-1:0]  in_flight;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy_q;
    logic              done_q;
    logic              ready;
    logic              accept;
    logic              wr_fire;

    // Admission: only while running, lines remain, and the memory window has room.
    always_comb begin
        in_flight = issued - written;
        ready     = (state == RUN) && (issued < len) && ({1'b0, in_flight} < DEPTH_LIM);
        accept    = ready && bus.cl_valid;
    end

    fixed_delay_line #(.LEN(FFT_LAT)) u_delay (
        .clk   (clk),
        .rst_n (reset),
        .din   (accept),
        .dout  (wr_fire)
    );

    // Job FSM with line/write counters and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            len     <= '0;
            issued  <= '0;
            written <= '0;
            wr_addr <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (accept) issued <= issued + 1'b1;
            if (wr_fire) begin
                written <= written + 1'b1;
                wr_addr <= (wr_addr == ADDR_LAST) ? '0 : wr_addr + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len     <= bus.num_lines;
                        issued  <= '0;
                        written <= '0;
                        wr_addr <= '0;
                        if (bus.num_lines == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issued == len) state <= DRAIN;
                end
                DRAIN: begin
                    // Look ahead by the current write so done lands one cycle after it.
                    if (written + CNT_W'(wr_fire) == len) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cl_ready = ready;
    assign bus.fft_next = accept;
    assign bus.mem_we   = wr_fire;
    assign bus.mem_addr = wr_addr;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_conv_fft_scheduler.sv
// Directed bench for conv_fft_scheduler: default build plus a small
// DEPTH=8 / FFT_LAT=12 build for backpressure and address wrap.
module tb_conv_fft_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int unsigned n_vec = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    conv_fft_scheduler_if #(.CNT_W(16), .ADDR_W(8)) bus_a ();
    conv_fft_scheduler_if #(.CNT_W(16), .ADDR_W(3)) bus_b ();

    conv_fft_scheduler #(.FFT_LAT(6), .DEPTH(256), .ADDR_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    conv_fft_scheduler #(.FFT_LAT(12), .DEPTH(8), .ADDR_W(3), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    typedef struct {
        logic        start;
        logic [15:0] num;
        logic        valid;
        logic        ready;
        logic        next;
        logic        we;
        logic [7:0]  addr;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, settle, then the caller samples.
    task automatic tick(input bit sel_b, input logic st, input logic [15:0] nl, input logic v);
        @(negedge clk);
        bus_a.start     = sel_b ? 1'b0 : st;
        bus_a.num_lines = sel_b ? 16'd0 : nl;
        bus_a.cl_valid  = sel_b ? 1'b0 : v;
        bus_b.start     = sel_b ? st : 1'b0;
        bus_b.num_lines = sel_b ? nl : 16'd0;
        bus_b.cl_valid  = sel_b ? v : 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] act;
        logic [15:0] tr_next, tr_we, tr_done, tr_ready, tr_busy;
        logic [7:0]  addrs[3];
        int unsigned nacc, nwr, ndone, done_cyc, last_wr, max_if, bp_seen, done_seen;

        // cycle-by-cycle trace of a 4-line job with cl_valid held high
        vecs[0]  = '{1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0};

        bus_a.start = 1'b0; bus_a.num_lines = '0; bus_a.cl_valid = 1'b0;
        bus_b.start = 1'b0; bus_b.num_lines = '0; bus_b.cl_valid = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_a", 32'({bus_a.cl_ready, bus_a.fft_next, bus_a.mem_we, bus_a.mem_addr, bus_a.busy, bus_a.done}), 32'd0);
        check("reset_b", 32'({bus_b.cl_ready, bus_b.fft_next, bus_b.mem_we, bus_b.mem_addr, bus_b.busy, bus_b.done}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 16'd0, 1'b0);

        // basic 4-line job, table driven
        for (int i = 0; i < 13; i++) begin
            tick(1'b0, vecs[i].start, vecs[i].num, vecs[i].valid);
            act = 32'({bus_a.cl_ready, bus_a.fft_next, bus_a.mem_we, bus_a.mem_addr, bus_a.busy, bus_a.done});
            check($sformatf("basic_c%0d", i), act,
                  32'({vecs[i].ready, vecs[i].next, vecs[i].we, vecs[i].addr, vecs[i].busy, vecs[i].done}));
        end
        repeat (2) tick(1'b0, 1'b0, 16'd0, 1'b0);

        // bubbles: 3 lines, cl_valid 1,0,0,1,1 from cycle 1
        tr_next = '0; tr_we = '0; tr_done = '0; nwr = 0;
        for (int c = 0; c < 16; c++) begin
            logic v;
            v = (c == 1) || (c == 4) || (c == 5);
            tick(1'b0, c == 0, 16'd3, v);
            tr_next[c] = bus_a.fft_next;
            tr_we[c]   = bus_a.mem_we;
            tr_done[c] = bus_a.done;
            if (bus_a.mem_we && nwr < 3) begin
                addrs[nwr] = bus_a.mem_addr;
                nwr++;
            end
        end
        check("bubble_next", 32'(tr_next), 32'h0032);
        check("bubble_we", 32'(tr_we), 32'h0C80);
        check("bubble_done", 32'(tr_done), 32'h1000);
        check("bubble_addrs", 32'({addrs[0], addrs[1], addrs[2]}), 32'h000102);
        repeat (2) tick(1'b0, 1'b0, 16'd0, 1'b0);

        // zero-length job
        tr_ready = '0; tr_next = '0; tr_we = '0; tr_done = '0; tr_busy = '0;
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, c == 0, 16'd0, 1'b1);
            tr_ready[c] = bus_a.cl_ready;
            tr_next[c]  = bus_a.fft_next;
            tr_we[c]    = bus_a.mem_we;
            tr_done[c]  = bus_a.done;
            tr_busy[c]  = bus_a.busy;
        end
        check("zero_ready", 32'(tr_ready), 32'h0);
        check("zero_traffic", 32'({tr_next, tr_we}), 32'h0);
        check("zero_done", 32'(tr_done), 32'h0002);
        check("zero_busy", 32'(tr_busy), 32'h0);
        repeat (2) tick(1'b0, 1'b0, 16'd0, 1'b0);

        // start with 99 lines pulsed mid-run must not disturb a 5-line job
        nacc = 0; nwr = 0; ndone = 0; done_cyc = 0;
        for (int c = 0; c < 30; c++) begin
            tick(1'b0, (c == 0) || (c == 3), (c == 3) ? 16'd99 : 16'd5, 1'b1);
            if (bus_a.fft_next) nacc++;
            if (bus_a.mem_we) nwr++;
            if (bus_a.done) begin
                ndone++;
                done_cyc = c;
            end
        end
        check("ign_accepts", nacc, 5);
        check("ign_writes", nwr, 5);
        check("ign_done_count", ndone, 1);
        check("ign_done_cycle", done_cyc, 12);
        check("ign_busy_end", 32'(bus_a.busy), 32'd0);
        repeat (2) tick(1'b0, 1'b0, 16'd0, 1'b0);

        // backpressure and wrap on the DEPTH=8, FFT_LAT=12 build
        nacc = 0; nwr = 0; max_if = 0; bp_seen = 0; done_seen = 0; last_wr = 0; done_cyc = 0;
        tick(1'b1, 1'b1, 16'd20, 1'b1);
        for (int c = 1; c < 300 && done_seen == 0; c++) begin
            tick(1'b1, 1'b0, 16'd0, 1'b1);
            if (bus_b.busy && !bus_b.cl_ready && nacc < 20) bp_seen = 1;
            if (bus_b.fft_next) nacc++;
            if (bus_b.mem_we) begin
                check($sformatf("wrap_addr%0d", nwr), 32'(bus_b.mem_addr), nwr % 8);
                nwr++;
                last_wr = c;
            end
            if (nacc - nwr > max_if) max_if = nacc - nwr;
            if (bus_b.done) begin
                done_seen = 1;
                done_cyc = c;
            end
        end
        check("wrap_done_seen", done_seen, 1);
        check("wrap_accepts", nacc, 20);
        check("wrap_writes", nwr, 20);
        check("wrap_max_inflight", max_if, 8);
        check("wrap_backpressure", bp_seen, 1);
        check("wrap_done_after_last", done_cyc, last_wr + 1);
        repeat (2) tick(1'b1, 1'b0, 16'd0, 1'b0);

        // reset mid-job after the third accepted line
        for (int c = 0; c < 4; c++) tick(1'b0, c == 0, 16'd10, 1'b1);
        check("abort_third_line", 32'(bus_a.fft_next), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("abort_outputs_zero",
              32'({bus_a.cl_ready, bus_a.fft_next, bus_a.mem_we, bus_a.mem_addr, bus_a.busy, bus_a.done}), 32'd0);
        repeat (2) tick(1'b0, 1'b0, 16'd0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        nacc = 0; nwr = 0; ndone = 0; max_if = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 1'b0, 16'd0, 1'b1);
            if (bus_a.fft_next) nacc++;
            if (bus_a.mem_we) nwr++;
            if (bus_a.done) ndone++;
            if (bus_a.busy) max_if++;
        end
        check("abort_no_we", nwr, 0);
        check("abort_no_done", ndone, 0);
        check("abort_no_next", nacc, 0);
        check("abort_not_busy", max_if, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
